fdiv_issue_unit: RTL and testbench



---
 rtl/fdiv_issue_unit.sv | 188 ++++++++++++++++++
 tb/tb_fdiv_issue_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_issue_unit.sv
// fdiv_issue_unit: tagged valid/ready issue and in-order writeback around Fdiv.
// Option macro FDIV_ISSUE_DZ_EN adds rsp_dz (divisor exponent zero flag).

// Pipelined single-precision divider: operand capture plus LAT-1 result regs
module Fdiv #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] r;
  logic [31:0] yp [LAT-1];
  logic        s;
  logic        za;
  logic        zb;
  logic        ia;
  logic        ib;
  logic        na;
  logic        nb;
  logic [9:0]  ex;
  logic [22:0] mant;
  logic [24:0] q;

  // operand capture
  always_ff @(posedge clk) begin
    a <= x1;
    b <= x2;
  end

  // mantissa divide, exponent adjust, special operands (denormals as zero)
  always_comb begin
    s  = a[31] ^ b[31];
    za = a[30:23] == 8'h00;
    zb = b[30:23] == 8'h00;
    ia = a[30:23] == 8'hFF;
    ib = b[30:23] == 8'hFF;
    na = ia && (a[22:0] != 23'h0);
    nb = ib && (b[22:0] != 23'h0);
    q  = 25'({1'b1, a[22:0], 24'h0} / {1'b1, b[22:0]});
    if (q[24]) begin
      mant = q[23:1];
      ex   = {2'b0, a[30:23]} - {2'b0, b[30:23]} + 10'd127;
    end else begin
      mant = q[22:0];
      ex   = {2'b0, a[30:23]} - {2'b0, b[30:23]} + 10'd126;
    end
    if (na || nb || (ia && ib) || (za && zb))
      r = 32'h7FC0_0000;
    else if (ia || zb)
      r = {s, 8'hFF, 23'h0};
    else if (za || ib)
      r = {s, 31'h0};
    else if (ex[9] || ex == 10'd0)
      r = {s, 31'h0};
    else if (ex[8:0] >= 9'd255)
      r = {s, 8'hFF, 23'h0};
    else
      r = {s, ex[7:0], mant};
  end

  // result delay line
  always_ff @(posedge clk) begin
    yp[0] <= r;
    for (int i = 1; i < LAT - 1; i++)
      yp[i] <= yp[i-1];
  end

  assign y = yp[LAT-2];
endmodule

module fdiv_issue_unit #(
  parameter int LAT        = 5,
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             flush,
`ifdef FDIV_ISSUE_DZ_EN
  output logic             rsp_dz,
`endif
  output logic             busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef FDIV_ISSUE_DZ_EN
  localparam int MW = TAG_W + 1;
`else
  localparam int MW = TAG_W;
`endif
  localparam int EW = 32 + MW;

  logic          accept;
  logic          pop;
  logic          push;
  logic          busy_q;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [PW:0]   wp;
  logic [PW:0]   rp;
  logic [LAT-1:0] sr_v;
  logic [MW-1:0] sr_m [LAT];
  logic [MW-1:0] meta_in;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [31:0]   fdiv_y;

  Fdiv #(.LAT(LAT)) u_fdiv (
    .clk (clk),
    .x1  (req_x1),
    .x2  (req_x2),
    .y   (fdiv_y)
  );

  assign req_ready = !flush && (out_cnt < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = wp != rp;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = sr_v[LAT-1] && !flush;
  assign head      = rsp_valid ? mem[rp[PW-1:0]] : '0;
  assign rsp_y     = head[EW-1 -: 32];
  assign rsp_tag   = head[MW-1 -: TAG_W];
  assign busy      = busy_q;
`ifdef FDIV_ISSUE_DZ_EN
  assign meta_in   = {req_tag, req_x2[30:23] == 8'h00};
  assign rsp_dz    = head[0];
`else
  assign meta_in   = req_tag;
`endif

  // credit count: in-flight ops plus FIFO occupancy
  always_comb begin
    cnt_nxt = out_cnt;
    if (flush)
      cnt_nxt = '0;
    else if (accept && !pop)
      cnt_nxt = out_cnt + 1'b1;
    else if (pop && !accept)
      cnt_nxt = out_cnt - 1'b1;
  end

  // control state: credits, valid shift register, FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt <= '0;
      busy_q  <= 1'b0;
      sr_v    <= '0;
      wp      <= '0;
      rp      <= '0;
    end else begin
      out_cnt <= cnt_nxt;
      busy_q  <= cnt_nxt != '0;
      if (flush) begin
        sr_v <= '0;
        wp   <= '0;
        rp   <= '0;
      end else begin
        sr_v <= {sr_v[LAT-2:0], accept};
        if (push)
          wp <= wp + 1'b1;
        if (pop)
          rp <= rp + 1'b1;
      end
    end
  end

  // tag/flag delay line and FIFO storage; qualified by valid bits
  always_ff @(posedge clk) begin
    sr_m[0] <= meta_in;
    for (int i = 1; i < LAT; i++)
      sr_m[i] <= sr_m[i-1];
    if (push)
      mem[wp[PW-1:0]] <= {fdiv_y, sr_m[LAT-1]};
  end
endmodule

// File: tb/tb_fdiv_issue_unit.sv
// tb_fdiv_issue_unit: directed checks of issue, ordering, credits,
// flush and reset for fdiv_issue_unit.
module tb_fdiv_issue_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_x1;
  logic [31:0] req_x2;
  logic [5:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic [5:0]  rsp_tag;
  logic        flush;
  logic        busy;
`ifdef FDIV_ISSUE_DZ_EN
  logic        rsp_dz;
`endif

  int checks   = 0;
  int failures = 0;
  int n;
  int first;
  int last;

  logic [31:0] vx1 [8];
  logic [31:0] vx2 [8];
  logic [31:0] vy  [8];

  fdiv_issue_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_tag   (rsp_tag),
    .flush     (flush),
`ifdef FDIV_ISSUE_DZ_EN
    .rsp_dz    (rsp_dz),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    vx1 = '{32'h40C00000, 32'h3F800000, 32'h41100000, 32'h3F800000,
            32'h41000000, 32'hC0C00000, 32'h3F800000, 32'h41200000};
    vx2 = '{32'h40000000, 32'h3F800000, 32'h40400000, 32'h40000000,
            32'h3F000000, 32'h40000000, 32'h40800000, 32'h40800000};
    vy  = '{32'h40400000, 32'h3F800000, 32'h40400000, 32'h3F000000,
            32'h41800000, 32'hC0400000, 32'h3E800000, 32'h40200000};

    rstn = 1'b0; req_valid = 1'b0; req_x1 = '0; req_x2 = '0;
    req_tag = '0; rsp_ready = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
`ifdef FDIV_ISSUE_DZ_EN
    chk("rst_rsp_dz", rsp_dz, 0);
`endif
    rstn = 1'b1;

    // single op: 6.0 / 2.0, tag 0x15
    @(negedge clk);
    req_valid = 1'b1; req_x1 = 32'h40C00000;
    req_x2 = 32'h40000000; req_tag = 6'h15;
    #1 chk("single_rdy", req_ready, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("single_vld", rsp_valid, 32'(k == 6));
      if (k == 6) begin
        chk("single_y", rsp_y, 32'h40400000);
        chk("single_tag", rsp_tag, 6'h15);
      end
      if (k == 1) chk("single_busy1", busy, 1);
      if (k == 7) chk("single_busy0", busy, 0);
    end

    // streaming: 8 back-to-back ops
    n = 0; first = -1; last = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k < 8) begin
        req_valid = 1'b1; req_x1 = vx1[k];
        req_x2 = vx2[k]; req_tag = 6'(k);
      end else
        req_valid = 1'b0;
      #1;
      if (k < 8) chk("stream_rdy", req_ready, 1);
      if (rsp_valid) begin
        if (n < 8) begin
          chk("stream_tag", rsp_tag, 32'(n));
          chk("stream_y", rsp_y, vy[n]);
        end
        if (first < 0) first = k;
        last = k;
        n++;
      end
    end
    chk("stream_n", n, 8);
    chk("stream_first", first, 6);
    chk("stream_last", last, 13);

    // backpressure: 12 cycles of requests with rsp_ready low
    rsp_ready = 1'b0; n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_x1 = vx1[k%8];
      req_x2 = vx2[k%8]; req_tag = 6'(8'h20 + k);
      #1;
      if (req_ready) n++;
    end
    chk("bp_accepts", n, 8);
    chk("bp_rdy_low", req_ready, 0);
    chk("bp_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    #1;
    chk("bp_head_vld", rsp_valid, 1);
    chk("bp_head_tag", rsp_tag, 6'h20);
    @(negedge clk);
    #1;
    chk("bp_hold_tag", rsp_tag, 6'h20);
    chk("bp_hold_y", rsp_y, vy[0]);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      if (k < 8) begin
        chk("bp_pop_vld", rsp_valid, 1);
        chk("bp_pop_tag", rsp_tag, 32'(8'h20 + k));
        chk("bp_pop_y", rsp_y, vy[k]);
        chk("bp_credit", req_ready, 32'(k > 0));
      end else begin
        chk("bp_drained", rsp_valid, 0);
        chk("bp_idle", busy, 0);
      end
    end

    // flush: 3 accepts, flush, then one fresh op
    n = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      req_valid = k < 5;
      req_x1 = vx1[7]; req_x2 = vx2[7];
      req_tag = (k < 3) ? 6'(8'h30 + k) : 6'h3A;
      flush = k == 3;
      #1;
      if (k == 3) chk("flush_rdy", req_ready, 0);
      if (k == 4) begin
        chk("flush_busy", busy, 0);
        chk("flush_rdy_back", req_ready, 1);
        chk("flush_vld", rsp_valid, 0);
        req_valid = 1'b1;
      end
      if (k == 5) req_valid = 1'b0;
      if (rsp_valid) begin
        n++;
        chk("flush_when", k, 10);
        chk("flush_tag", rsp_tag, 6'h3A);
        chk("flush_y", rsp_y, vy[7]);
      end
    end
    chk("flush_n", n, 1);

    // reset with 2 ops queued and 4 in flight
    rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = k < 6;
      req_x1 = vx1[0]; req_x2 = vx2[0]; req_tag = 6'(8'h10 + k);
    end
    #1 chk("rst_pre_vld", rsp_valid, 1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_vld", rsp_valid, 0);
    chk("arst_y", rsp_y, 0);
    chk("arst_tag", rsp_tag, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1; rsp_ready = 1'b1; n = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) n++;
    end
    chk("rst_no_rsp", n, 0);

`ifdef FDIV_ISSUE_DZ_EN
    // divide-by-zero flag
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_valid = k < 2;
      req_x1 = 32'h3F800000;
      req_x2 = (k == 0) ? 32'h00000000 : 32'h3F800000;
      req_tag = 6'(k);
      #1;
      if (rsp_valid) begin
        if (n == 0) begin
          chk("dz_flag1", rsp_dz, 1);
          chk("dz_y_inf", rsp_y, 32'h7F800000);
        end else begin
          chk("dz_flag0", rsp_dz, 0);
          chk("dz_y_one", rsp_y, 32'h3F800000);
        end
        n++;
      end
    end
    chk("dz_n", n, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
